// File: rtl/avr_uart_pkg.sv
// Shared types and constants for the AVR serial link receiver.
// Purely declarative: no latency, no flow control.
package avr_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int AVR_CLK_PER_BIT = 100;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; 2-cycle latency.
// No flow control; both flops reset to RESET_VAL so an idle-high line reads idle during reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avr_uart_rx.sv
// 8N1 (8E1 with AVR_UART_RX_PARITY_EN) receiver; strobe at detect + CLK_PER_BIT/2 + 9 (10) bits + 1 cycle.
// No backpressure: each result is a one-cycle strobe that must be consumed when it appears.
module avr_uart_rx
  import avr_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = AVR_CLK_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      new_data,
  output logic                      frame_err,
  output logic                      parity_err
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_prev;
  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bit_end;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign bit_end = (cnt == BIT_CNT);

`ifdef AVR_UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_prev   <= rx_s;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        // rx_prev must have seen the line high, so a held break never retriggers.
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s && rx_prev) state <= START;
        end
        START: begin
          if (cnt == MID_CNT) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef AVR_UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef AVR_UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_bad <= rx_s ^ (^shreg);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef AVR_UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
`endif
            end else begin
              data     <= shreg;
              new_data <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_uart_rx.sv
// Directed bench for avr_uart_rx: table of single frames plus back-to-back, glitch and reset sequences.
module tb_avr_uart_rx;
  import avr_uart_pkg::*;

  localparam int CLK_PER_BIT = 100;
`ifdef AVR_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // 2 sync cycles to detect, half a bit to mid-start, (FRAME_BITS-1) bits to mid-stop, 1 register.
  localparam int LAT = 2 + CLK_PER_BIT / 2 + (FRAME_BITS - 1) * CLK_PER_BIT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       parity_err;

  avr_uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .new_data   (new_data),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: kind = {parity_err, frame_err, new_data}
  int         ev_cyc[$];
  logic [2:0] ev_kind[$];
  logic [7:0] ev_data[$];

  always @(negedge clk) begin
    if (!rst && (new_data || frame_err || parity_err)) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back({parity_err, frame_err, new_data});
      ev_data.push_back(data);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CLK_PER_BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef AVR_UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) $display("note: parity bit unknown");
`endif
    send_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CLK_PER_BIT) @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    ev_cyc.delete();
    ev_kind.delete();
    ev_data.delete();
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop_b;
    logic       par_b;
    logic [2:0] exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   f_cyc;

  initial begin
    vecs.push_back('{din: 8'hA5, stop_b: 1'b1, par_b: 1'b0, exp_kind: 3'b001, exp_data: 8'hA5});
    vecs.push_back('{din: 8'h3C, stop_b: 1'b0, par_b: 1'b0, exp_kind: 3'b010, exp_data: 8'hA5});
    vecs.push_back('{din: 8'h5A, stop_b: 1'b1, par_b: 1'b0, exp_kind: 3'b001, exp_data: 8'h5A});
`ifdef AVR_UART_RX_PARITY_EN
    vecs.push_back('{din: 8'h03, stop_b: 1'b1, par_b: 1'b1, exp_kind: 3'b100, exp_data: 8'h5A});
    vecs.push_back('{din: 8'h03, stop_b: 1'b1, par_b: 1'b0, exp_kind: 3'b001, exp_data: 8'h03});
`endif

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_new_data", 32'(new_data), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // Single frames from the table
    for (int v = 0; v < vecs.size(); v++) begin
      clear_ev();
      f_cyc = cyc;
      send_frame(vecs[v].din, vecs[v].stop_b, vecs[v].par_b);
      idle_bits(2);
      chk($sformatf("v%0d_count", v), 32'(ev_cyc.size()), 32'd1);
      if (ev_cyc.size() >= 1) begin
        chk($sformatf("v%0d_kind", v), 32'(ev_kind[0]), 32'(vecs[v].exp_kind));
        chk($sformatf("v%0d_latency", v), 32'(ev_cyc[0] - f_cyc), 32'(LAT));
      end
      chk($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
    end

    // Back-to-back frames, no idle bits between them
    clear_ev();
    f_cyc = cyc;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    chk("b2b_count", 32'(ev_cyc.size()), 32'd2);
    if (ev_cyc.size() >= 2) begin
      chk("b2b_kind0", 32'(ev_kind[0]), 32'b001);
      chk("b2b_data0", 32'(ev_data[0]), 32'h00);
      chk("b2b_latency0", 32'(ev_cyc[0] - f_cyc), 32'(LAT));
      chk("b2b_kind1", 32'(ev_kind[1]), 32'b001);
      chk("b2b_data1", 32'(ev_data[1]), 32'hFF);
      chk("b2b_spacing", 32'(ev_cyc[1] - ev_cyc[0]), 32'(FRAME_BITS * CLK_PER_BIT));
    end

    // Short low glitch: rejected at mid-start
    clear_ev();
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle_bits(3);
    chk("glitch_count", 32'(ev_cyc.size()), 32'd0);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    chk("glitch_data", 32'(data), 32'hFF);

    // Reset during bit 4, then a clean frame
    clear_ev();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_new_data", 32'(new_data), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    chk("midrst_parity_err", 32'(parity_err), 32'h0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(6);
    chk("midrst_no_strobe", 32'(ev_cyc.size()), 32'd0);

    clear_ev();
    f_cyc = cyc;
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    chk("post_rst_count", 32'(ev_cyc.size()), 32'd1);
    if (ev_cyc.size() >= 1) begin
      chk("post_rst_kind", 32'(ev_kind[0]), 32'b001);
      chk("post_rst_latency", 32'(ev_cyc[0] - f_cyc), 32'(LAT));
    end
    chk("post_rst_data", 32'(data), 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
